// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from an async-read code RAM,
// queues words for decode and applies branch/jump redirects. FETCH_PERF_EN adds perf counters.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        hold,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_off,
  input  logic        jmp,
  input  logic [25:0] jmp_idx,
  output logic [1:0]  fsm_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int            AW = $clog2(QDEPTH);
  localparam logic [AW:0]   QD = (AW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     count;
  logic [31:0]     q_pc   [QDEPTH];
  logic [31:0]     q_inst [QDEPTH];

  logic            redirect_req;
  logic            redirect;
  logic            push;
  logic            pop;
  logic [31:0]     pc4;
  logic [31:0]     br_target;
  logic [31:0]     jmp_target;
  logic [31:0]     target;

  assign pc4        = br_pc + 32'd4;
  assign br_target  = pc4 + {{14{br_off[15]}}, br_off, 2'b00};
  assign jmp_target = {pc4[31:28], jmp_idx, 2'b00};
  assign target     = jmp ? jmp_target : br_target;

  assign redirect_req = br_taken || jmp;
  // A redirect seen while IDLE is dropped entirely: no PC load, no flush.
  assign redirect     = redirect_req && (state != IDLE);
  assign pop          = if_valid && if_ready;
  assign push         = (state == RUN) && !hold && !redirect_req && ((count < QD) || pop);

  assign if_valid  = (count != '0);
  assign if_inst   = if_valid ? q_inst[head] : '0;
  assign if_pc     = if_valid ? q_pc[head]   : '0;
  assign imem_addr = pc;
  assign fsm_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE:    if (start && !halt) state <= RUN;
        RUN:     if (halt) state <= HALTED;
        HALTED:  if (redirect || (start && !halt)) state <= RUN;
        default: state <= IDLE;
      endcase

      if (redirect) begin
        pc    <= target;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc   <= pc + 32'd4;
          tail <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; count alone decides which entries are
  // visible, so stale words are never presented after reset or a flush.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= imem_inst;
    end
  end

`ifdef FETCH_PERF_EN
  logic [AW:0] flush_n;
  logic [32:0] flush_sum;

  // The entry popped in the redirect cycle reached decode, so it is not a flush.
  assign flush_n   = count - (AW+1)'(pop);
  assign flush_sum = {1'b0, perf_flushed} + 33'(flush_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushed <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a per-cycle vector table plus hand-written
// sequences for halt/redirect, PC wrap, mid-stream reset and redirect-in-IDLE.
module tb_inst_fetch_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, hold, if_ready, br_taken, jmp;
  logic [31:0] br_pc;
  logic [15:0] br_off;
  logic [25:0] jmp_idx;
  logic [31:0] imem_addr, imem_inst, if_inst, if_pc;
  logic        if_valid;
  logic [1:0]  fsm_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_addr[9:2]];

  inst_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .hold(hold),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .br_taken(br_taken), .br_pc(br_pc), .br_off(br_off),
    .jmp(jmp), .jmp_idx(jmp_idx), .fsm_state(fsm_state)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  typedef struct {
    logic        st, hl, ho, rd, bt, jm;
    logic [31:0] bpc;
    logic [15:0] boff;
    logic [25:0] jidx;
    logic        e_valid;
    logic [31:0] e_inst, e_pc, e_addr;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] m(input int i);
    if (i == 0) return 32'h0042_1821;
    if (i == 1) return 32'h0062_1822;
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] einst,
                           input logic [31:0] epc, input logic [31:0] eaddr, input logic [1:0] est);
    check({tag, ".if_valid"},  32'(if_valid),  32'(ev));
    check({tag, ".if_inst"},   if_inst,        einst);
    check({tag, ".if_pc"},     if_pc,          epc);
    check({tag, ".imem_addr"}, imem_addr,      eaddr);
    check({tag, ".fsm_state"}, 32'(fsm_state), 32'(est));
  endtask

  task automatic drive(input logic st, hl, ho, rd, bt, jm, input logic [31:0] bpc,
                       input logic [15:0] boff, input logic [25:0] jidx);
    start = st; halt = hl; hold = ho; if_ready = rd;
    br_taken = bt; jmp = jm; br_pc = bpc; br_off = boff; jmp_idx = jidx;
  endtask

  task automatic add(input logic st, hl, ho, rd, bt, jm, input logic [31:0] bpc,
                     input logic [15:0] boff, input logic [25:0] jidx, input logic ev,
                     input logic [31:0] einst, epc, eaddr, input logic [1:0] est);
    vec_t v;
    v.st = st; v.hl = hl; v.ho = ho; v.rd = rd; v.bt = bt; v.jm = jm;
    v.bpc = bpc; v.boff = boff; v.jidx = jidx;
    v.e_valid = ev; v.e_inst = einst; v.e_pc = epc; v.e_addr = eaddr; v.e_state = est;
    vecs.push_back(v);
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic step(input logic st, hl, ho, rd, bt, jm, input logic [31:0] bpc,
                      input logic [15:0] boff, input logic [25:0] jidx);
    drive(st, hl, ho, rd, bt, jm, bpc, boff, jidx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = m(i);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    rst_n = 1'b0;
    #2;
    check_out("reset", 0, 32'h0, 32'h0, 32'h0, S_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;

    //  st hl ho rd bt jm  br_pc        br_off    jmp_idx  | valid inst    pc          addr         state
    add(1, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     0, 32'h0,  32'h0,      32'h0,       S_RUN);   // 0 start
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(0),   32'h0,      32'h4,       S_RUN);   // 1 first valid
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(0),   32'h0,      32'h8,       S_RUN);   // 2 full
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(0),   32'h0,      32'h8,       S_RUN);   // 3 stalled
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(0),   32'h0,      32'h8,       S_RUN);   // 4
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(0),   32'h0,      32'h8,       S_RUN);   // 5
    add(0, 0, 0, 1, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(1),   32'h4,      32'hC,       S_RUN);   // 6 push+pop full
    add(0, 0, 0, 1, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(2),   32'h8,      32'h10,      S_RUN);   // 7
    add(0, 0, 0, 0, 0, 1, 32'h20,      16'h0,    26'hA,     0, 32'h0,  32'h0,      32'h28,      S_RUN);   // 8 jmp flush 2
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(10),  32'h28,     32'h2C,      S_RUN);   // 9 target head
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(10),  32'h28,     32'h30,      S_RUN);   // 10
    add(0, 0, 0, 1, 1, 1, 32'h30,      16'hFFF4, 26'h10,    0, 32'h0,  32'h0,      32'h40,      S_RUN);   // 11 jmp wins
    add(0, 0, 0, 1, 1, 0, 32'h30,      16'hFFF4, 26'h0,     0, 32'h0,  32'h0,      32'h4,       S_RUN);   // 12 back branch
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(1),   32'h4,      32'h8,       S_RUN);   // 13
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(1),   32'h4,      32'hC,       S_RUN);   // 14 full
    add(0, 1, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(1),   32'h4,      32'hC,       S_HALT);  // 15 halt
    add(0, 0, 0, 1, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(2),   32'h8,      32'hC,       S_HALT);  // 16 drain
    add(0, 0, 0, 1, 0, 0, 32'h0,       16'h0,    26'h0,     0, 32'h0,  32'h0,      32'hC,       S_HALT);  // 17 empty
    add(1, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     0, 32'h0,  32'h0,      32'hC,       S_RUN);   // 18 restart
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(3),   32'hC,      32'h10,      S_RUN);   // 19 resume held pc
    add(0, 0, 1, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(3),   32'hC,      32'h10,      S_RUN);   // 20 hold
    add(0, 0, 1, 1, 0, 0, 32'h0,       16'h0,    26'h0,     0, 32'h0,  32'h0,      32'h10,      S_RUN);   // 21 pop under hold
    add(0, 0, 0, 1, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(4),   32'h10,     32'h14,      S_RUN);   // 22
    add(0, 0, 0, 1, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(5),   32'h14,     32'h18,      S_RUN);   // 23
    add(0, 0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     1, m(5),   32'h14,     32'h1C,      S_RUN);   // 24

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].hl, vecs[i].ho, vecs[i].rd, vecs[i].bt, vecs[i].jm,
           vecs[i].bpc, vecs[i].boff, vecs[i].jidx);
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc,
                vecs[i].e_addr, vecs[i].e_state);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched.table", perf_fetched, 32'd12);
    check("perf_flushed.table", perf_flushed, 32'd3);
`endif

    // Redirect while HALTED loads the target and re-enters RUN.
    step(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    check_out("halt2", 1, m(5), 32'h14, 32'h1C, S_HALT);
    step(0, 0, 0, 0, 0, 1, 32'h20, 16'h0, 26'h8);
    check_out("halt_redir", 0, 32'h0, 32'h0, 32'h20, S_RUN);
    step(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    check_out("halt_redir_fetch", 1, m(8), 32'h20, 32'h24, S_RUN);

    // PC wraps modulo 2^32; high addresses alias in the 256-word RAM.
    step(0, 0, 0, 1, 0, 1, 32'hFFFF_FFF0, 16'h0, 26'h3FF_FFFF);
    check_out("wrap_jmp", 0, 32'h0, 32'h0, 32'hFFFF_FFFC, S_RUN);
    step(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    check_out("wrap_fetch", 1, m(255), 32'hFFFF_FFFC, 32'h0, S_RUN);
    step(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    check_out("wrap_next", 1, m(255), 32'hFFFF_FFFC, 32'h4, S_RUN);
`ifdef FETCH_PERF_EN
    check("perf_fetched.wrap", perf_fetched, 32'd15);
    check("perf_flushed.wrap", perf_flushed, 32'd5);
`endif

    // Asynchronous reset with two entries queued empties the queue at once.
    rst_n = 1'b0;
    #2;
    check_out("async_reset", 0, 32'h0, 32'h0, 32'h0, S_IDLE);
`ifdef FETCH_PERF_EN
    check("perf_fetched.reset", perf_fetched, 32'd0);
    check("perf_flushed.reset", perf_flushed, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Redirect in IDLE is ignored.
    step(0, 0, 0, 1, 0, 1, 32'h20, 16'h0, 26'hA);
    check_out("idle_redir", 0, 32'h0, 32'h0, 32'h0, S_IDLE);
    step(0, 0, 0, 1, 1, 0, 32'h30, 16'hFFF4, 26'h0);
    check_out("idle_branch", 0, 32'h0, 32'h0, 32'h0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
